// File: rtl/exu_fpu_wb_ctl.sv
// FPU writeback buffer and floating-point CSR state (frm, fflags).
// Completed results are queued here, drained to the FP regfile, and their flags are accrued when they pop.
module exu_fpu_wb_ctl #(
  parameter int DEPTH = 2,
  parameter int RDW   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [RDW-1:0]             in_rd,
  input  logic [4:0]                 in_status,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [31:0]                wb_data,
  output logic [RDW-1:0]             wb_rd,
  input  logic                       csr_wen,
  input  logic [11:0]                csr_addr,
  input  logic [31:0]                csr_wdata,
  output logic [31:0]                csr_rdata,
  output logic [2:0]                 frm,
  output logic [4:0]                 fflags,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  logic [31:0]    result_mem [DEPTH];
  logic [RDW-1:0] rd_mem     [DEPTH];
  logic [4:0]     status_mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [4:0]    fflags_reg;
  logic [4:0]    fflags_next;
  logic [2:0]    frm_reg;
  logic [2:0]    frm_next;
  logic          push;
  logic          pop;
  logic          unused_wdata;

  // Upper write-data bits have no architectural home.
  assign unused_wdata = ^csr_wdata[31:8];

  assign in_ready = ~rst & ~flush & (count_reg != CW'(DEPTH));
  assign wb_valid = ~rst & ~flush & (count_reg != '0);
  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  assign wb_data  = result_mem[rd_ptr_reg];
  assign wb_rd    = rd_mem[rd_ptr_reg];
  assign frm      = frm_reg;
  assign fflags   = fflags_reg;
  assign count    = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // A CSR write to the flag field overrides accrual from a same-cycle pop.
  always_comb begin
    fflags_next = fflags_reg;
    frm_next    = frm_reg;
    if (pop)
      fflags_next = fflags_reg | status_mem[rd_ptr_reg];
    if (csr_wen) begin
      case (csr_addr)
        ADDR_FFLAGS: fflags_next = csr_wdata[4:0];
        ADDR_FRM:    frm_next    = csr_wdata[2:0];
        ADDR_FCSR: begin
          frm_next    = csr_wdata[7:5];
          fflags_next = csr_wdata[4:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      ADDR_FFLAGS: csr_rdata = {27'b0, fflags_reg};
      ADDR_FRM:    csr_rdata = {29'b0, frm_reg};
      ADDR_FCSR:   csr_rdata = {24'b0, frm_reg, fflags_reg};
      default:     csr_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr_reg] <= in_result;
      rd_mem[wr_ptr_reg]     <= in_rd;
      status_mem[wr_ptr_reg] <= in_status;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fflags_reg <= '0;
      frm_reg    <= '0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_next;
      end
      fflags_reg <= fflags_next;
      frm_reg    <= frm_next;
    end
  end

endmodule

// File: tb/tb_exu_fpu_wb_ctl.sv
// Directed bench for exu_fpu_wb_ctl (DEPTH=2, RDW=5) with hand-computed expectations.
module tb_exu_fpu_wb_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic [4:0]  in_status;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [2:0]  frm;
  logic [4:0]  fflags;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exu_fpu_wb_ctl #(.DEPTH(2), .RDW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_rd(in_rd), .in_status(in_status), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .frm(frm), .fflags(fflags), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wen = 1'b1; csr_addr = a; csr_wdata = d;
    step();
    csr_wen = 1'b0;
  endtask

  task automatic push(input logic [31:0] r, input logic [4:0] d, input logic [4:0] s);
    in_valid = 1'b1; in_result = r; in_rd = d; in_status = s;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = '0; in_status = '0;
    flush = 1'b0; wb_ready = 1'b0; csr_wen = 1'b0; csr_addr = '0; csr_wdata = '0;
    step(); step();

    // reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fflags", 32'(fflags), 32'd0);
    check("rst_frm", 32'(frm), 32'd0);
    rst = 1'b0; #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // single result
    wb_ready = 1'b1;
    push(32'h3F80_0000, 5'd3, 5'h01);
    check("single_wb_valid", 32'(wb_valid), 32'd1);
    check("single_wb_data", wb_data, 32'h3F80_0000);
    check("single_wb_rd", 32'(wb_rd), 32'd3);
    check("single_fflags_pre", 32'(fflags), 32'd0);
    step();
    csr_addr = 12'h001; #1;
    check("single_fflags", 32'(fflags), 32'h01);
    check("single_csr_fflags", csr_rdata, 32'h01);
    check("single_empty", 32'(wb_valid), 32'd0);

    // backpressure / full
    wb_ready = 1'b0;
    push(32'hA1, 5'd1, 5'h00);
    push(32'hA2, 5'd2, 5'h00);
    check("full_count", 32'(count), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push(32'hA7, 5'd7, 5'h1F);
    check("full_refused_count", 32'(count), 32'd2);
    check("full_head_stable", 32'(wb_rd), 32'd1);
    wb_ready = 1'b1; #1;
    check("full_in_ready_pop", 32'(in_ready), 32'd0);
    step();
    check("bp_second_rd", 32'(wb_rd), 32'd2);
    check("bp_second_data", wb_data, 32'hA2);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    step();
    check("bp_drained", 32'(wb_valid), 32'd0);
    check("bp_fflags_kept", 32'(fflags), 32'h01);

    // wrap-around stream of 10
    csr_write(12'h001, 32'h0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_result = 32'h100 + 32'(i);
      in_status = (i == 2) ? 5'h04 : (i == 7) ? 5'h10 : 5'h00;
      #1;
      if (i > 0) begin
        check($sformatf("wrap_valid_%0d", i), 32'(wb_valid), 32'd1);
        check($sformatf("wrap_rd_%0d", i), 32'(wb_rd), 32'(i - 1));
      end
      step();
    end
    in_valid = 1'b0; #1;
    check("wrap_last_rd", 32'(wb_rd), 32'd9);
    check("wrap_last_data", wb_data, 32'h109);
    step();
    check("wrap_fflags", 32'(fflags), 32'h14);

    // flush discards without accruing flags
    csr_write(12'h001, 32'h0);
    wb_ready = 1'b0;
    push(32'hB0, 5'd4, 5'h10);
    push(32'hB1, 5'd5, 5'h04);
    flush = 1'b1; wb_ready = 1'b1; #1;
    check("flush_wb_valid", 32'(wb_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_wb_valid_after", 32'(wb_valid), 32'd0);
    check("flush_fflags", 32'(fflags), 32'd0);

    // CSR access
    csr_write(12'h003, 32'hA5);
    csr_addr = 12'h003; #1;
    check("csr_frm", 32'(frm), 32'd5);
    check("csr_fflags", 32'(fflags), 32'h05);
    check("csr_fcsr_rd", csr_rdata, 32'hA5);
    csr_addr = 12'h002; #1;
    check("csr_frm_rd", csr_rdata, 32'd5);
    csr_write(12'h7FF, 32'hFF);
    csr_addr = 12'h7FF; #1;
    check("csr_unmapped_rd", csr_rdata, 32'd0);
    check("csr_unmapped_wr", 32'(frm), 32'd5);
    wb_ready = 1'b0;
    push(32'hC0, 5'd6, 5'h02);
    wb_ready = 1'b1; csr_wen = 1'b1; csr_addr = 12'h001; csr_wdata = 32'h0; #1;
    check("csr_pre_write_rd", csr_rdata, 32'h05);
    check("csr_pop_valid", 32'(wb_valid), 32'd1);
    step();
    csr_wen = 1'b0; #1;
    check("csr_beats_pop", 32'(fflags), 32'd0);
    check("csr_pop_count", 32'(count), 32'd0);

    // flush and CSR write together
    wb_ready = 1'b0;
    push(32'hD0, 5'd8, 5'h08);
    flush = 1'b1; csr_wen = 1'b1; csr_addr = 12'h002; csr_wdata = 32'h3;
    step();
    flush = 1'b0; csr_wen = 1'b0; #1;
    check("flushcsr_frm", 32'(frm), 32'd3);
    check("flushcsr_count", 32'(count), 32'd0);

    // reset mid-stream
    push(32'hE0, 5'd9, 5'h08);
    push(32'hE1, 5'd10, 5'h08);
    check("mid_count", 32'(count), 32'd2);
    rst = 1'b1;
    step();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_fflags", 32'(fflags), 32'd0);
    check("mid_rst_frm", 32'(frm), 32'd0);
    check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    wb_ready = 1'b1;
    step();
    check("mid_rel_fflags", 32'(fflags), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
